// File: rtl/score_uart_pkg.sv
// rtl/score_uart_pkg.sv - shared types, ASCII constants and helpers for the score UART transmitter
package score_uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SEND    = 2'd2,
        GAP     = 2'd3
    } state_t;

    localparam logic [7:0] CH_S    = 8'h53;
    localparam logic [7:0] CH_G    = 8'h47;
    localparam logic [7:0] CH_O    = 8'h4F;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_ZERO = 8'h30;

    // Byte counts per message: 'S' + 3 digits + EOL, 'G' 'O' + EOL.
    localparam logic [2:0] SCORE_LEN_CRLF = 3'd6;
    localparam logic [2:0] SCORE_LEN_LF   = 3'd5;
    localparam logic [2:0] GO_LEN_CRLF    = 3'd4;
    localparam logic [2:0] GO_LEN_LF      = 3'd3;

    // Double-dabble digit correction applied before each shift.
    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // BCD digit to its ASCII character.
    function automatic logic [7:0] bcd_ascii(input logic [3:0] d);
        return CH_ZERO + {4'd0, d};
    endfunction

endpackage

// File: rtl/bin2bcd8.sv
// rtl/bin2bcd8.sv - sequential 8-step double-dabble binary to 3-digit BCD converter
module bin2bcd8
    import score_uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        done,
    output logic [11:0] bcd
);

    logic [7:0]  bin_q, bin_d;
    logic [11:0] bcd_q, bcd_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        run_q, run_d;
    logic [11:0] adj;

    // Conversion registers; bcd_q holds its result until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= 8'd0;
            bcd_q <= 12'd0;
            cnt_q <= 3'd0;
            run_q <= 1'b0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    // Add-3 correction of each BCD digit ahead of the shift.
    always_comb begin
        adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    end

    // Load on start, then one shift per cycle for eight cycles.
    always_comb begin
        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start) begin
            bin_d = bin;
            bcd_d = 12'd0;
            cnt_d = 3'd0;
            run_d = 1'b1;
        end else if (run_q) begin
            {bcd_d, bin_d} = {adj, bin_q} << 1;
            cnt_d          = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                run_d = 1'b0;
            end
        end
    end

    // done marks the cycle whose closing edge performs the final shift.
    always_comb begin
        done = run_q && (cnt_q == 3'd7);
        bcd  = bcd_q;
    end

endmodule

// File: rtl/score_uart_tx.sv
// rtl/score_uart_tx.sv - UART transmitter that reports score changes and game-over events as ASCII lines
module score_uart_tx
    import score_uart_pkg::*;
#(
    parameter bit CRLF = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] score,
    input  logic       gameover,
    input  logic       txready,
    output logic [7:0] txdata,
    output logic       txclk,
    output logic       busy
);

    localparam logic [2:0] SCORE_LAST = CRLF ? (SCORE_LEN_CRLF - 3'd1) : (SCORE_LEN_LF - 3'd1);
    localparam logic [2:0] GO_LAST    = CRLF ? (GO_LEN_CRLF - 3'd1)    : (GO_LEN_LF - 3'd1);
    localparam logic [7:0] CH_EOL1    = CRLF ? CH_CR : CH_LF;

    state_t      state_q, state_d;
    logic [7:0]  last_score_q, last_score_d;
    logic        go_pending_q, go_pending_d;
    logic        gameover_q, gameover_d;
    logic        msg_go_q, msg_go_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  txdata_q, txdata_d;
    logic        txclk_q, txclk_d;

    logic        score_evt;
    logic        go_evt;
    logic        go_rise;
    logic        last_byte;
    logic [7:0]  cur_byte;
    logic        bcd_done;
    logic [11:0] bcd;

    // Score changes outrank a pending game-over; both only start when enabled.
    assign score_evt = (state_q == IDLE) && en && (score != last_score_q);
    assign go_evt    = (state_q == IDLE) && en && go_pending_q;
    assign go_rise   = gameover && !gameover_q;
    assign last_byte = msg_go_q ? (idx_q == GO_LAST) : (idx_q == SCORE_LAST);

    bin2bcd8 u_bin2bcd8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (score_evt),
        .bin   (score),
        .done  (bcd_done),
        .bcd   (bcd)
    );

    // State and datapath registers; reset aborts any message in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_score_q <= 8'd0;
            go_pending_q <= 1'b0;
            gameover_q   <= 1'b0;
            msg_go_q     <= 1'b0;
            idx_q        <= 3'd0;
            txdata_q     <= 8'h00;
            txclk_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_score_q <= last_score_d;
            go_pending_q <= go_pending_d;
            gameover_q   <= gameover_d;
            msg_go_q     <= msg_go_d;
            idx_q        <= idx_d;
            txdata_q     <= txdata_d;
            txclk_q      <= txclk_d;
        end
    end

    // Next-state: convert only for score lines, SEND/GAP alternate per byte.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (score_evt) begin
                    state_d = CONVERT;
                end else if (go_evt) begin
                    state_d = SEND;
                end
            end
            CONVERT: begin
                if (bcd_done) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (txready) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = last_byte ? IDLE : SEND;
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte selection from message type and index.
    always_comb begin
        cur_byte = CH_LF;
        if (msg_go_q) begin
            case (idx_q)
                3'd0:    cur_byte = CH_G;
                3'd1:    cur_byte = CH_O;
                3'd2:    cur_byte = CH_EOL1;
                default: cur_byte = CH_LF;
            endcase
        end else begin
            case (idx_q)
                3'd0:    cur_byte = CH_S;
                3'd1:    cur_byte = bcd_ascii(bcd[11:8]);
                3'd2:    cur_byte = bcd_ascii(bcd[7:4]);
                3'd3:    cur_byte = bcd_ascii(bcd[3:0]);
                3'd4:    cur_byte = CH_EOL1;
                default: cur_byte = CH_LF;
            endcase
        end
    end

    // Output/datapath updates; a game-over rising edge is latched in every state.
    always_comb begin
        last_score_d = last_score_q;
        go_pending_d = go_pending_q;
        gameover_d   = gameover;
        msg_go_d     = msg_go_q;
        idx_d        = idx_q;
        txdata_d     = txdata_q;
        txclk_d      = txclk_q;
        case (state_q)
            IDLE: begin
                if (score_evt) begin
                    last_score_d = score;
                    msg_go_d     = 1'b0;
                    idx_d        = 3'd0;
                end else if (go_evt) begin
                    go_pending_d = 1'b0;
                    msg_go_d     = 1'b1;
                    idx_d        = 3'd0;
                end
            end
            SEND: begin
                if (txready) begin
                    txclk_d  = 1'b1;
                    txdata_d = cur_byte;
                end
            end
            GAP: begin
                txclk_d = 1'b0;
                idx_d   = idx_q + 3'd1;
            end
            default: ;
        endcase
        if (go_rise) begin
            go_pending_d = 1'b1;
        end
    end

    assign txdata = txdata_q;
    assign txclk  = txclk_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_score_uart_tx.sv
// tb/tb_score_uart_tx.sv - directed self-checking bench for score_uart_tx
module tb_score_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] score;
    logic       gameover;
    logic       txready;
    logic [7:0] txdata;
    logic       txclk;
    logic       busy;

    logic [7:0] score0;
    logic       gameover0;
    logic       txready0;
    logic [7:0] txdata0;
    logic       txclk0;
    logic       busy0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int stall_viol = 0;
    int data_viol = 0;
    logic       rdy_e = 1'b1;
    logic [7:0] prev_txdata = 8'h00;

    logic [7:0] got_q[$];
    int         got_cyc[$];
    logic [7:0] got0_q[$];
    logic [7:0] exp_q[$];

    score_uart_tx #(.CRLF(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .score(score), .gameover(gameover),
        .txready(txready), .txdata(txdata), .txclk(txclk), .busy(busy)
    );

    score_uart_tx #(.CRLF(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .score(score0), .gameover(gameover0),
        .txready(txready0), .txdata(txdata0), .txclk(txclk0), .busy(busy0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rdy_e <= txready;
    end

    always @(negedge clk) begin
        if (txclk === 1'b1) begin
            got_q.push_back(txdata);
            got_cyc.push_back(cyc);
            if (rdy_e !== 1'b1) stall_viol = stall_viol + 1;
        end
        if (txclk0 === 1'b1) got0_q.push_back(txdata0);
        if (rst_n === 1'b1 && txclk === 1'b0 && txdata !== prev_txdata) data_viol = data_viol + 1;
        prev_txdata = txdata;
    end

    task automatic wait_quiet(input int bound);
        int q;
        q = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (busy === 1'b0) q++; else q = 0;
            if (q == 4) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; score = 8'd0; gameover = 1'b0; txready = 1'b1;
        score0 = 8'd0; gameover0 = 1'b0; txready0 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (txdata !== 8'h00) begin failures++; $display("FAIL rst_txdata got=%02h want=00", txdata); end
        checks++; if (txclk !== 1'b0) begin failures++; $display("FAIL rst_txclk got=%b want=0", txclk); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", busy); end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (busy !== 1'b0 || got_q.size() != 0) begin
            failures++; $display("FAIL rst_idle busy=%b bytes=%0d want busy=0 bytes=0", busy, got_q.size());
        end
    endtask

    task automatic test_score7();
        int c0, fall;
        got_q.delete(); got_cyc.delete();
        exp_q = '{8'h53, 8'h30, 8'h30, 8'h37, 8'h0D, 8'h0A};
        @(posedge clk); #1 score = 8'd7; c0 = cyc + 1;
        fall = -1;
        @(posedge clk);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin fall = cyc; break; end
        end
        checks++; if (fall != c0 + 20) begin failures++; $display("FAIL s7_busy_fall got=%0d want=%0d", fall - c0, 20); end
        checks++; if (got_cyc.size() == 0 || got_cyc[0] != c0 + 9) begin
            failures++; $display("FAIL s7_first_txclk got=%0d want=%0d", (got_cyc.size() == 0) ? -1 : got_cyc[0] - c0, 9);
        end
        for (int i = 1; i < got_cyc.size(); i++) begin
            checks++; if (got_cyc[i] - got_cyc[i-1] != 2) begin
                failures++; $display("FAIL s7_spacing idx=%0d got=%0d want=2", i, got_cyc[i] - got_cyc[i-1]);
            end
        end
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL s7_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL s7_byte idx=%0d got=%02h want=%02h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_score255();
        got_q.delete(); got_cyc.delete();
        exp_q = '{8'h53, 8'h32, 8'h35, 8'h35, 8'h0D, 8'h0A};
        @(posedge clk); #1 score = 8'd255;
        wait_quiet(100);
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL s255_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL s255_byte idx=%0d got=%02h want=%02h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_crlf0();
        got0_q.delete();
        exp_q = '{8'h53, 8'h32, 8'h30, 8'h30, 8'h0A};
        @(posedge clk); #1 score0 = 8'd200;
        repeat (40) @(negedge clk);
        checks++; if (got0_q.size() != exp_q.size()) begin failures++; $display("FAIL lf_count got=%0d want=%0d", got0_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got0_q.size(); i++) begin
            checks++; if (got0_q[i] !== exp_q[i]) begin failures++; $display("FAIL lf_byte idx=%0d got=%02h want=%02h", i, got0_q[i], exp_q[i]); end
        end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL lf_busy got=%b want=0", busy0); end
    endtask

    task automatic test_enable();
        got_q.delete(); got_cyc.delete();
        exp_q = '{8'h53, 8'h30, 8'h37, 8'h37, 8'h0D, 8'h0A};
        @(posedge clk); #1 en = 1'b0; score = 8'd77;
        repeat (30) @(negedge clk);
        checks++; if (got_q.size() != 0 || busy !== 1'b0) begin
            failures++; $display("FAIL en_off bytes=%0d busy=%b want bytes=0 busy=0", got_q.size(), busy);
        end
        @(posedge clk); #1 en = 1'b1;
        wait_quiet(100);
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL en_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL en_byte idx=%0d got=%02h want=%02h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_stall();
        int snap_s, snap_d;
        got_q.delete(); got_cyc.delete();
        exp_q = '{8'h53, 8'h30, 8'h34, 8'h32, 8'h0D, 8'h0A};
        snap_s = stall_viol; snap_d = data_viol;
        @(posedge clk); #1 score = 8'd42;
        for (int i = 0; i < 400 && got_q.size() < 6; i++) begin
            @(posedge clk); #1 txready = 1'($urandom_range(0, 1));
        end
        txready = 1'b1;
        wait_quiet(60);
        checks++; if (stall_viol != snap_s) begin failures++; $display("FAIL stall_txclk got=%0d want=0", stall_viol - snap_s); end
        checks++; if (data_viol != snap_d) begin failures++; $display("FAIL stall_hold got=%0d want=0", data_viol - snap_d); end
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL stall_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL stall_byte idx=%0d got=%02h want=%02h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_simul();
        int c0;
        got_q.delete(); got_cyc.delete();
        exp_q = '{8'h53, 8'h30, 8'h31, 8'h30, 8'h0D, 8'h0A, 8'h47, 8'h4F, 8'h0D, 8'h0A};
        @(posedge clk); #1 score = 8'd10; gameover = 1'b1; c0 = cyc + 1;
        repeat (6) @(negedge clk);
        checks++; if (dut.go_pending_q !== 1'b1) begin failures++; $display("FAIL sim_pending_set got=%b want=1", dut.go_pending_q); end
        for (int i = 0; i < 100 && got_q.size() < 7; i++) @(negedge clk);
        checks++; if (got_cyc.size() < 7 || got_cyc[6] != c0 + 22) begin
            failures++; $display("FAIL sim_go_start got=%0d want=%0d", (got_cyc.size() < 7) ? -1 : got_cyc[6] - c0, 22);
        end
        checks++; if (dut.go_pending_q !== 1'b0) begin failures++; $display("FAIL sim_pending_clr got=%b want=0", dut.go_pending_q); end
        wait_quiet(100);
        gameover = 1'b0;
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL sim_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL sim_byte idx=%0d got=%02h want=%02h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_collapse();
        got_q.delete(); got_cyc.delete();
        exp_q = '{8'h53, 8'h30, 8'h30, 8'h35, 8'h0D, 8'h0A, 8'h53, 8'h30, 8'h30, 8'h38, 8'h0D, 8'h0A};
        @(posedge clk); #1 score = 8'd5;
        repeat (12) @(posedge clk); #1 score = 8'd6;
        repeat (4) @(posedge clk); #1 score = 8'd7;
        repeat (3) @(posedge clk); #1 score = 8'd8;
        wait_quiet(150);
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL col_busy got=%b want=0", busy); end
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL col_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL col_byte idx=%0d got=%02h want=%02h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        got_q.delete(); got_cyc.delete();
        exp_q = '{8'h53, 8'h30, 8'h30, 8'h39, 8'h0D, 8'h0A};
        @(posedge clk); #1 score = 8'd100;
        for (int i = 0; i < 100 && got_q.size() < 3; i++) @(negedge clk);
        #1 rst_n = 1'b0; score = 8'd9;
        #1;
        checks++; if (txclk !== 1'b0) begin failures++; $display("FAIL rmid_txclk got=%b want=0", txclk); end
        checks++; if (txdata !== 8'h00) begin failures++; $display("FAIL rmid_txdata got=%02h want=00", txdata); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b want=0", busy); end
        repeat (3) @(posedge clk);
        got_q.delete(); got_cyc.delete();
        #1 rst_n = 1'b1;
        wait_quiet(100);
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rmid_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rmid_byte idx=%0d got=%02h want=%02h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_score7();
        test_score255();
        test_crlf0();
        test_enable();
        test_stall();
        test_simul();
        test_collapse();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
